// File: rtl/serial_rx.sv
// serial_rx: 8051 serial port mode 1 receive engine (start, 8 data LSB first, stop),
// sampled at a 16x oversampled baud with a 2-of-3 majority vote per bit.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   baud_tick        - one-cycle strobe at 16x baud
//   ren, sm2         - SCON.REN receive enable, SCON.SM2 stop-bit qualification
//   rxd              - asynchronous receive pin
//   ri_clr           - software clear of RI (also clears frame_err)
//   sbuf, rb8, ri    - received byte, received stop bit, receive-complete flag
//   frame_err        - last stop bit was sampled as 0
module serial_rx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       ren,
    input  logic       sm2,
    input  logic       rxd,
    input  logic       ri_clr,
    output logic [7:0] sbuf,
    output logic       rb8,
    output logic       ri,
    output logic       frame_err
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IDX_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_S7   = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_S8   = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_S9   = CNT_W'(9);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic              rxd_s1, rxd_s2, rxd_q;
    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  bit_idx, bit_idx_d;
    logic              smp7, smp7_d, smp8, smp8_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [DATA_W-1:0] sbuf_d;
    logic              rb8_d, ri_d, frame_err_d;
    logic              vote_c;

    // Two-flop synchronizer plus previous-value register for falling-edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    // Majority of the samples at cnt 7, 8 and the live sample at cnt 9
    assign vote_c = (smp7 & smp8) | (smp7 & rxd_s2) | (smp8 & rxd_s2);

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            smp7      <= 1'b1;
            smp8      <= 1'b1;
            shreg     <= '0;
            sbuf      <= '0;
            rb8       <= 1'b0;
            ri        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            smp7      <= smp7_d;
            smp8      <= smp8_d;
            shreg     <= shreg_d;
            sbuf      <= sbuf_d;
            rb8       <= rb8_d;
            ri        <= ri_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_idx_d   = bit_idx;
        smp7_d      = smp7;
        smp8_d      = smp8;
        shreg_d     = shreg;
        sbuf_d      = sbuf;
        rb8_d       = rb8;
        ri_d        = ri;
        frame_err_d = frame_err;

        // Clear first so a same-cycle set below takes precedence
        if (ri_clr) begin
            ri_d        = 1'b0;
            frame_err_d = 1'b0;
        end

        if ((state != IDLE) && !ren) begin
            state_d = IDLE;
        end else if (state == IDLE) begin
            if (ren && rxd_q && !rxd_s2) begin
                cnt_d   = '0;
                state_d = START;
            end
        end else if (baud_tick) begin
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_S7) smp7_d = rxd_s2;
            if (cnt == CNT_S8) smp8_d = rxd_s2;

            case (state)
                START: begin
                    if ((cnt == CNT_S9) && vote_c) begin
                        state_d = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (cnt == CNT_S9) shreg_d = {vote_c, shreg[DATA_W-1:1]};
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == IDX_LAST) state_d = STOP;
                        else                     bit_idx_d = bit_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_S9) begin
                        // ri_d already reflects a same-cycle software clear
                        if (!ri_d && (!sm2 || vote_c)) begin
                            sbuf_d = shreg;
                            rb8_d  = vote_c;
                            ri_d   = 1'b1;
                        end
                        frame_err_d = ~vote_c;
                        state_d     = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed self-checking bench for serial_rx.
// Each baud tick spans 4 clocks; rxd changes at the start of a tick period.
module tb_serial_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       ren;
    logic       sm2;
    logic       rxd;
    logic       ri_clr;
    logic [7:0] sbuf;
    logic       rb8;
    logic       ri;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    serial_rx #(.OVERSAMPLE(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick),
        .ren       (ren),
        .sm2       (sm2),
        .rxd       (rxd),
        .ri_clr    (ri_clr),
        .sbuf      (sbuf),
        .rb8       (rb8),
        .ri        (ri),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    // One baud tick: drive the line level, strobe baud_tick (optionally with ri_clr)
    task automatic do_tick(input logic b, input logic clr);
        rxd = b;
        repeat (3) @(negedge clock);
        baud_tick = 1'b1;
        ri_clr    = clr;
        @(negedge clock);
        baud_tick = 1'b0;
        ri_clr    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0);
    endtask

    // Frame ticks [from, to): tick 16*k..16*k+15 carries bit k (start, d0..d7, stop)
    task automatic send_range(input logic [7:0] d, input logic stopb, input int from,
                              input int to, input int flip, input int clr_at);
        for (int i = from; i < to; i++) begin
            int   idx;
            logic b;
            idx = i / 16;
            if (idx == 0)      b = 1'b0;
            else if (idx <= 8) b = d[idx-1];
            else if (idx == 9) b = stopb;
            else               b = 1'b1;
            if (i == flip) b = ~b;
            do_tick(b, (i == clr_at) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb);
        idle(2);
        send_range(d, stopb, 0, 160, -1, -1);
    endtask

    task automatic clear_ri();
        @(negedge clock);
        ri_clr = 1'b1;
        @(negedge clock);
        ri_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; baud_tick = 1'b0; ren = 1'b1; sm2 = 1'b0; rxd = 1'b1; ri_clr = 1'b0;
        repeat (3) @(negedge clock);
        check8("rst_sbuf", sbuf, 8'h00);
        check1("rst_rb8", rb8, 1'b0);
        check1("rst_ri", ri, 1'b0);
        check1("rst_ferr", frame_err, 1'b0);
        reset = 1'b0;
        idle(4);

        // 0xA5, stop=1: ri rises exactly on the 154th tick
        idle(2);
        send_range(8'hA5, 1'b1, 0, 153, -1, -1);
        check1("a5_ri_before", ri, 1'b0);
        send_range(8'hA5, 1'b1, 153, 154, -1, -1);
        check1("a5_ri", ri, 1'b1);
        check8("a5_sbuf", sbuf, 8'hA5);
        check1("a5_rb8", rb8, 1'b1);
        check1("a5_ferr", frame_err, 1'b0);
        send_range(8'hA5, 1'b1, 154, 160, -1, -1);
        clear_ri();
        check1("a5_ri_clr", ri, 1'b0);

        // Short low glitch: false start, nothing loaded
        for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
        idle(28);
        check1("glitch_ri", ri, 1'b0);
        check8("glitch_sbuf", sbuf, 8'hA5);
        send_frame(8'h3C, 1'b1);
        check8("3c_sbuf", sbuf, 8'h3C);
        check1("3c_ri", ri, 1'b1);
        clear_ri();

        // 0x81 with stop=0: sm2=1 discards, sm2=0 loads
        sm2 = 1'b1;
        send_frame(8'h81, 1'b0);
        check1("81sm2_ri", ri, 1'b0);
        check1("81sm2_ferr", frame_err, 1'b1);
        check8("81sm2_sbuf", sbuf, 8'h3C);
        clear_ri();
        check1("ferr_clr", frame_err, 1'b0);
        sm2 = 1'b0;
        send_frame(8'h81, 1'b0);
        check8("81_sbuf", sbuf, 8'h81);
        check1("81_rb8", rb8, 1'b0);
        check1("81_ri", ri, 1'b1);
        check1("81_ferr", frame_err, 1'b1);
        clear_ri();

        // Overrun: second byte discarded while ri=1
        send_frame(8'h11, 1'b1);
        check8("11_sbuf", sbuf, 8'h11);
        send_frame(8'h22, 1'b1);
        check8("ovr_sbuf", sbuf, 8'h11);
        check1("ovr_ri", ri, 1'b1);
        // ri_clr in the load cycle: the set wins
        idle(2);
        send_range(8'h33, 1'b1, 0, 160, -1, 153);
        check1("33_ri", ri, 1'b1);
        check8("33_sbuf", sbuf, 8'h33);
        clear_ri();

        // One corrupted sample (cnt 8 of data bit 3)
        idle(2);
        send_range(8'h08, 1'b1, 0, 160, 72, -1);
        check8("corrupt_sbuf", sbuf, 8'h08);
        check1("corrupt_ri", ri, 1'b1);
        clear_ri();

        // ren dropped for one clock during bit 4; line stays high afterwards
        idle(2);
        send_range(8'hF0, 1'b1, 0, 85, -1, -1);
        @(negedge clock); ren = 1'b0;
        @(negedge clock); ren = 1'b1;
        send_range(8'hF0, 1'b1, 85, 160, -1, -1);
        check1("ren_ri", ri, 1'b0);
        check8("ren_sbuf", sbuf, 8'h08);

        // Mid-frame reset clears outputs immediately
        send_frame(8'hC3, 1'b0);
        check8("c3_sbuf", sbuf, 8'hC3);
        check1("c3_ri", ri, 1'b1);
        idle(2);
        send_range(8'h5A, 1'b1, 0, 70, -1, -1);
        reset = 1'b1;
        #1;
        check8("mrst_sbuf", sbuf, 8'h00);
        check1("mrst_rb8", rb8, 1'b0);
        check1("mrst_ri", ri, 1'b0);
        check1("mrst_ferr", frame_err, 1'b0);
        rxd = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(4);
        send_frame(8'h5A, 1'b1);
        check8("5a_sbuf", sbuf, 8'h5A);
        check1("5a_ri", ri, 1'b1);
        check1("5a_rb8", rb8, 1'b1);
        check1("5a_ferr", frame_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

UART receive engine for the 8051 core's serial port in mode 1: 10-bit frames of start, 8 data bits LSB first, and stop, received at a 16x oversampled baud. It sits beside the SFR block inside `top`. It samples the external RXD pin and delivers received bytes into SBUF. It raises RI/RB8 with 8051 semantics, including the SM2 stop-bit qualification. It is the receiving counterpart of the serial transmit path.

## Interface
Parameters:
- `OVERSAMPLE`, 16: baud ticks per bit. The counter is 4 bits wide and only 16 is supported.

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; forces every register to its reset value immediately.
- `baud_tick` in 1: one-cycle strobe at 16x baud, from the timer 1 overflow divider.
- `ren` in 1: SCON.REN receive enable.
- `sm2` in 1: SCON.SM2 stop-bit qualification.
- `rxd` in 1: P3.0 pin; asynchronous to `clock`.
- `ri_clr` in 1: one-cycle pulse from a software write that clears SCON.RI.
- `sbuf` out 8: received byte register. Reset value 0x00.
- `rb8` out 1: received stop bit. Reset value 0.
- `ri` out 1: receive-complete flag. Reset value 0.
- `frame_err` out 1: stop bit sampled as 0. Reset value 0.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset to 1. A third register `rxd_q` holds the previous synchronized value for edge detection.
- Sample counter `cnt` is 4 bits:
  - It advances only on `baud_tick` and wraps from 15 to 0.
  - Majority vote of the synchronized `rxd` is taken on the ticks where `cnt` = 7, 8 and 9, judged on the value before increment.
- States:
  - **IDLE:** when `ren`=1 and a falling edge is seen (`rxd_q`=1 and synchronized `rxd`=0), set `cnt`=0 and go to START.
  - **START:**
    - On the `cnt`=9 tick, if the vote is 1, the start is false; return to IDLE with no side effects.
    - On the `cnt`=15 tick, go to DATA with bit index 0.
  - **DATA:**
    - The vote at `cnt`=9 is shifted into bit 7 of an 8-bit shift register, which shifts right, so the data arrives LSB first.
    - On the `cnt`=15 tick of bit index 7, go to STOP.
  - **STOP:** on the `cnt`=9 tick the vote is the stop bit `s`.
    - If `ri`=0 and (`sm2`=0 or `s`=1), load `sbuf` with the shift register, set `rb8`=`s` and set `ri`=1.
    - Otherwise discard the byte. `sbuf`, `rb8` and `ri` are unchanged; this covers the overrun case.
    - `frame_err` is set to ~`s` unconditionally.
    - Go to IDLE mid-stop-bit, ready for the next falling edge.
- `ren` falling to 0 in any non-IDLE state aborts to IDLE on the next clock. No output changes.
- `ri_clr` clears both `ri` and `frame_err`. If `ri_clr` arrives in the same cycle as a set, the set wins.
- `ri` stays at 1 until `ri_clr`; it never clears itself.
- A mid-frame `reset` returns the FSM to IDLE and all outputs to their reset values. The synchronizer returns to 1.

## Timing
- Pin-to-FSM latency is 2 clocks from the synchronizer, plus 1 clock for edge detection.
- The start edge is detected on a clock edge and does not need a `baud_tick`.
- Outputs `sbuf`, `rb8`, `ri` and `frame_err` update on the clock edge of the 154th `baud_tick` after start detection:
  - START: 16 ticks.
  - DATA: 128 ticks.
  - STOP: 10 ticks.
- These outputs are visible from the following cycle.
- A new start edge can be accepted from the first clock after the return to IDLE. The remaining stop-bit time is tolerated.
- Glitch rejection: a low pulse shorter than about 8 ticks fails the start vote.
- Every bit decision needs only 2 of its 3 samples to agree.
- `baud_tick` held low freezes the FSM and `cnt`. No timeout applies.

## Test plan
- Frame 0xA5 with stop=1, `ren`=1, `sm2`=0 -> `sbuf`=0xA5, `rb8`=1, `ri`=1, `frame_err`=0, with `ri` rising on the 154th tick.
- `rxd` low for 4 ticks, then high -> FSM returns to IDLE. `ri`=0 and `sbuf` is unchanged. A following 0x3C frame is received correctly.
- Frame 0x81 with stop=0:
  - With `sm2`=1 -> no load, `ri`=0, `frame_err`=1.
  - Repeated with `sm2`=0 -> `sbuf`=0x81, `rb8`=0, `ri`=1, `frame_err`=1.
- 0x11 received, `ri` left at 1, then 0x22 sent -> `sbuf` stays 0x11.
  - Pulse `ri_clr` in exactly the load cycle of a third frame, 0x33 -> `ri`=1 and `sbuf`=0x33.
- A single sample corrupted in data bit 3 (one of cnt 7/8/9) -> byte still correct.
- `ren` dropped during bit 4 -> no load. Asserting `reset` mid-frame -> all outputs return to 0 at once. After release, 0x5A is received correctly.
